// File: rtl/pc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_pkg : shared operation encoding, defaults and priority decode |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package pc_pkg;

  localparam int PC_ADDR_W_DEF      = 4;
  localparam int PC_STACK_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CNT  = 3'd1,
    OP_JMP  = 3'd2,
    OP_REL  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } pc_op_e;

  // Single source of truth for the control priority: ret > call > jump > rel > count.
  function automatic pc_op_e pc_decode(input logic ret_n,
                                       input logic call_n,
                                       input logic j_n,
                                       input logic rel_n,
                                       input logic ce);
    pc_op_e op;
    op = OP_HOLD;
    if (!ret_n)       op = OP_RET;
    else if (!call_n) op = OP_CALL;
    else if (!j_n)    op = OP_JMP;
    else if (!rel_n)  op = OP_REL;
    else if (ce)      op = OP_CNT;
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ret_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_ret_stack : parametrised return-address LIFO with push/pop    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pc_ret_stack #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         clr_n_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 data_i,
  output logic [W-1:0]                 data_o,
  output logic [$clog2(DEPTH+1)-1:0]   sp_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic [SP_W-1:0]  sp_d;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o   = (sp_q == SP_W'(DEPTH));
  assign empty_o  = (sp_q == '0);
  assign sp_o     = sp_q;

  // Pop wins if both are requested; an illegal push/pop is silently dropped.
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && !pop_i && !full_o;

  assign w_wr_idx = sp_q[IDX_W-1:0];
  assign w_rd_idx = IDX_W'(sp_q - SP_W'(1));
  assign data_o   = mem_q[w_rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (w_do_pop)       sp_d = sp_q - SP_W'(1);
    else if (w_do_push) sp_d = sp_q + SP_W'(1);
  end

  always_ff @(posedge clk or negedge clr_n_i) begin
    if (!clr_n_i) sp_q <= '0;
    else          sp_q <= sp_d;
  end

  // Entry contents need no reset; only sp defines validity.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[w_wr_idx] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/pc_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_stack : program counter with CALL/RET stack and bus interface |
// | Optional macro PC_REL_JUMP_EN adds rel_n (pc += signed bus).     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pc_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W      = PC_ADDR_W_DEF,
  parameter int STACK_DEPTH = PC_STACK_DEPTH_DEF
) (
  input  logic                              clk,
  input  logic                              clr_n,
  input  logic                              ce,
  input  logic                              j_n,
  input  logic                              call_n,
  input  logic                              ret_n,
`ifdef PC_REL_JUMP_EN
  input  logic                              rel_n,
`endif
  input  logic                              co_n,
  inout  wire  [ADDR_W-1:0]                 bus,
  output logic [ADDR_W-1:0]                 pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]  sp,
  output logic                              stk_full,
  output logic                              stk_ovf,
  output logic                              stk_unf
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              unf_q;
  logic              unf_d;

  logic [ADDR_W-1:0] w_bus_in;
  logic [ADDR_W-1:0] w_top;
  logic              w_rel_n;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  pc_op_e            w_op;

  assign bus      = co_n ? {ADDR_W{1'bz}} : pc_q;
  assign w_bus_in = bus;

`ifdef PC_REL_JUMP_EN
  assign w_rel_n = rel_n;
`else
  assign w_rel_n = 1'b1;
`endif

  assign w_op   = pc_decode(ret_n, call_n, j_n, w_rel_n, ce);
  assign w_push = (w_op == OP_CALL);
  assign w_pop  = (w_op == OP_RET);

  pc_ret_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .clr_n_i (clr_n),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (pc_q),
    .data_o  (w_top),
    .sp_o    (sp),
    .full_o  (stk_full),
    .empty_o (w_empty)
  );

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    case (w_op)
      OP_RET: begin
        if (!w_empty) pc_d  = w_top;
        else          unf_d = 1'b1;
      end
      // A CALL into a full stack still takes the branch; only the push is lost.
      OP_CALL: begin
        pc_d = w_bus_in;
        if (stk_full) ovf_d = 1'b1;
      end
      OP_JMP:  pc_d = w_bus_in;
`ifdef PC_REL_JUMP_EN
      // Same-width add is the modulo sum with the bus read as two's complement.
      OP_REL:  pc_d = pc_q + w_bus_in;
`endif
      OP_CNT:  pc_d = pc_q + ADDR_W'(1);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc      = pc_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pc_stack : directed self-checking bench with reference model  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_pc_stack;

  localparam int AW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          ce = 1'b0;
  logic          j_n = 1'b1;
  logic          call_n = 1'b1;
  logic          ret_n = 1'b1;
  logic          rel_n = 1'b1;
  logic          co_n = 1'b1;
  logic [AW-1:0] bus_drv = '0;
  wire  [AW-1:0] bus;
  logic [AW-1:0] pc;
  logic [2:0]    sp;
  logic          stk_full;
  logic          stk_ovf;
  logic          stk_unf;

  // The bench owns the bus whenever the PC is not driving it.
  assign bus = co_n ? bus_drv : {AW{1'bz}};

  pc_stack #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .ce       (ce),
    .j_n      (j_n),
    .call_n   (call_n),
    .ret_n    (ret_n),
`ifdef PC_REL_JUMP_EN
    .rel_n    (rel_n),
`endif
    .co_n     (co_n),
    .bus      (bus),
    .pc       (pc),
    .sp       (sp),
    .stk_full (stk_full),
    .stk_ovf  (stk_ovf),
    .stk_unf  (stk_unf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  logic [AW-1:0] m_pc = '0;
  logic [AW-1:0] m_stk [$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = '0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Architectural rules: highest-priority asserted control decides the edge.
  task automatic model_step();
    logic [AW-1:0] bv;
    bv = co_n ? bus_drv : m_pc;
    if (!ret_n) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else                  m_unf = 1'b1;
    end else if (!call_n) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(m_pc);
      else                      m_ovf = 1'b1;
      m_pc = bv;
    end else if (!j_n) begin
      m_pc = bv;
    end else if (!rel_n) begin
      m_pc = m_pc + bv;
    end else if (ce) begin
      m_pc = m_pc + 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc",       int'(pc),       int'(m_pc));
      chk("sp",       int'(sp),       m_stk.size());
      chk("stk_full", int'(stk_full), int'(m_stk.size() == DEPTH));
      chk("stk_ovf",  int'(stk_ovf),  int'(m_ovf));
      chk("stk_unf",  int'(stk_unf),  int'(m_unf));
      chk("bus",      int'(bus),      int'(co_n ? bus_drv : m_pc));
    end
  end

  task automatic cyc(input logic i_ce, input logic i_j, input logic i_call,
                     input logic i_ret, input logic i_rel, input logic i_co,
                     input logic [AW-1:0] d);
    ce = i_ce; j_n = i_j; call_n = i_call; ret_n = i_ret; rel_n = i_rel;
    co_n = i_co; bus_drv = d;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic jmp(input logic [AW-1:0] d);  cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, d); endtask
  task automatic call(input logic [AW-1:0] d); cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, d); endtask
  task automatic ret();                        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0); endtask

  initial begin
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    clr_n  = 1'b1;
    chk_en = 1'b1;
    chk("reset_pc",  int'(pc),      0);
    chk("reset_sp",  int'(sp),      0);
    chk("reset_ovf", int'(stk_ovf), 0);
    chk("reset_unf", int'(stk_unf), 0);

    // Count 17 times, alternating bus ownership; bench pattern always differs from pc.
    for (int i = 0; i < 17; i++)
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, logic'(i % 2 == 0), m_pc ^ 4'hF);
    chk("count_wrap_pc", int'(pc), 1);

    jmp(4'd5);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
    chk("jump_over_count", int'(pc), 9);

    jmp(4'd2);
    call(4'd8);
    chk("call1_pc", int'(pc), 8);
    chk("call1_sp", int'(sp), 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    call(4'd12);
    chk("call2_pc", int'(pc), 12);
    chk("call2_sp", int'(sp), 2);
    // RET must win over concurrent jump and count.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd15);
    chk("ret1_pc", int'(pc), 9);
    ret();
    chk("ret2_pc", int'(pc), 2);
    chk("ret2_sp", int'(sp), 0);

    // Fill: pushes 2,1,2,3 then overflow on the fifth CALL.
    call(4'd1); call(4'd2); call(4'd3); call(4'd4);
    chk("fill_full", int'(stk_full), 1);
    call(4'd7);
    chk("ovf_pc",  int'(pc),      7);
    chk("ovf_sp",  int'(sp),      4);
    chk("ovf_flg", int'(stk_ovf), 1);
    ret(); chk("pop1", int'(pc), 3);
    ret(); chk("pop2", int'(pc), 2);
    ret(); chk("pop3", int'(pc), 1);
    ret(); chk("pop4", int'(pc), 2);

    // CALL with pc on the bus reloads its own value but still pushes.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    chk("selfcall_pc", int'(pc), 2);
    chk("selfcall_sp", int'(sp), 1);
    ret();
    ret();
    chk("unf_pc",  int'(pc),      2);
    chk("unf_flg", int'(stk_unf), 1);
    chk("ovf_sticky", int'(stk_ovf), 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);

`ifdef PC_REL_JUMP_EN
    jmp(4'd3);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1110);
    chk("rel_neg", int'(pc), 1);
    jmp(4'd14);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0011);
    chk("rel_wrap", int'(pc), 1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd4);
    chk("jmp_over_rel", int'(pc), 4);
`endif

    // Asynchronous reset in the middle of a cycle.
    jmp(4'd6);
    #2;
    clr_n = 1'b0;
    model_reset();
    #1;
    chk("async_pc",  int'(pc),      0);
    chk("async_sp",  int'(sp),      0);
    chk("async_ovf", int'(stk_ovf), 0);
    chk("async_unf", int'(stk_unf), 0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    chk("post_reset_cnt", int'(pc), 1);
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Second-generation program counter for the 8-bit CPU.
- Parametrised address width, with a hardware return-address stack that adds CALL/RET on top of count, jump and bus output.
- Drives its value onto the shared tri-state bus on request and captures jump targets from it.
- Sits between the bus and the control sequencer, replacing the fixed 4-bit counter.

Parameters:
- ADDR_W, 4, PC and bus-side address width in bits (legal range 2..8).
- STACK_DEPTH, 4, number of return-address entries (legal range 1..16).

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- clr_n  in  1  asynchronous active-low reset; clears PC, stack pointer and flags.
- ce  in  1  count enable, active high; PC <= PC+1.
- j_n  in  1  jump, active low; PC <= bus.
- call_n  in  1  call, active low; push PC, then PC <= bus.
- ret_n  in  1  return, active low; PC <= popped entry.
- co_n  in  1  output enable, active low; drives PC onto bus.
- bus  inout  ADDR_W  shared bus; high-Z when co_n=1.
- pc  out  ADDR_W  current PC, always valid (debug/sequencer use).
- sp  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stk_full  out  1  combinational, sp==STACK_DEPTH.
- stk_ovf  out  1  sticky overflow flag.
- stk_unf  out  1  sticky underflow flag.

Behaviour:
- Reset (clr_n=0, asynchronous, any time):
  - pc=0, sp=0, stk_ovf=0, stk_unf=0, stack contents don't-care.
  - bus follows co_n combinationally during reset and drives 0 if co_n=0.
- Bus output: bus = co_n ? 'z : pc, purely combinational, zero-cycle latency.
- One operation per cycle, selected at the rising edge by fixed priority: ret_n > call_n > j_n > ce > hold.
- RET, sp>0:
  - pc <= stack[sp-1], sp <= sp-1.
  - Concurrent ce/j_n/call_n are ignored.
- RET, sp==0:
  - pc holds, stk_unf <= 1, sp stays 0.
- CALL, sp<STACK_DEPTH:
  - stack[sp] <= pc, sp <= sp+1, pc <= bus.
  - Pushed value is the pre-edge pc (fetch has already incremented it).
- CALL, sp==STACK_DEPTH:
  - pc <= bus (the jump still happens), push discarded, stk_ovf <= 1, sp unchanged.
- JUMP: pc <= bus.
- COUNT: pc <= pc+1 modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0 with no flag.
- Hold: no control asserted, all state unchanged.
- co_n=0 together with j_n/call_n=0: the bus carries pc, so the load is legal and pc reloads its own value; a CALL still pushes.
- Flags:
  - Sticky; cleared only by clr_n.
  - Changes to sp, stk_ovf and stk_unf are visible the cycle after the edge.
- Latency: every PC update is one cycle; outputs are registered except bus and stk_full.

Optional Feature:
- Macro: PC_REL_JUMP_EN.
- Defined:
  - Adds input port rel_n (active low, priority between j_n and ce).
  - pc <= pc + sign-extended bus, modulo 2^ADDR_W; bus is read as two's-complement.
  - Example (ADDR_W=4): pc=3, bus=4'b1110 gives pc=1.
- Undefined:
  - Port rel_n does not exist; no relative adder is synthesised.

Decomposition:
- Shared package pc_pkg holds:
  - Operation-select encoding constants: OP_HOLD, OP_CNT, OP_JMP, OP_REL, OP_CALL, OP_RET.
  - Default ADDR_W and STACK_DEPTH constants.
  - The priority order, so the sequencer and bench agree on it.
- Sub-module pc_ret_stack:
  - Parametrised LIFO (width ADDR_W, depth STACK_DEPTH) with push/pop, sp, full/empty.
  - Reset on clr_n; no flag logic.
- Top level pc_stack: priority decode, PC register, bus driver, flags.

Test Plan:
- Reset then count: clr_n pulse, ce=1 for 17 cycles (ADDR_W=4) -> pc 0,1,…,15,0,1; bus high-Z while co_n=1; bus=pc in the same cycle when co_n=0.
- Jump vs count priority: pc=5, j_n=0, ce=1, bus=9 -> pc=9 next cycle, not 6.
- Nested call/return: pc=2 CALL bus=8, pc=8→9 CALL bus=12, RET, RET -> pc 8,9,12,9,2; sp 1,2,1,0; no flags.
- Overflow: 4 CALLs fill the stack, 5th CALL bus=7 -> pc=7, sp=4, stk_ovf=1, stk_full=1; the next 4 RETs return the first 4 pushed values.
- Underflow and reset mid-operation: RET with sp=0 -> pc unchanged, stk_unf=1; then clr_n low asynchronously mid-cycle -> pc=0, sp=0, both flags 0 before the next edge.
- PC_REL_JUMP_EN build: pc=3, rel_n=0, bus=4'b1110 -> pc=1; pc=14, bus=4'b0011 -> pc=1 (wrap); rel_n with j_n=0 -> the jump wins.
